serial_subtractor_64bits: RTL and testbench

//  Multi-cycle 64-bit subtract-with-borrow unit: diff = a - b - b_in (mod 2^WIDTH), b_out = final borrow.

---
 rtl/serial_subtractor_64bits_pkg.sv | 23 ++
 rtl/serial_subtractor_64bits_sub_slice.sv | 15 +
 rtl/serial_subtractor_64bits.sv | 125 ++++++++++++
 tb/tb_serial_subtractor_64bits.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_64bits_pkg.sv
// Shared types and sizing helpers for the chunked 64-bit subtract-with-borrow unit.
// Holds the FSM state encoding, the default widths and the chunk-count/index-width math.
package serial_subtractor_64bits_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 64;
  localparam int CHUNK_DEF = 16;

  function automatic int n_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_64bits_sub_slice.sv
// Combinational CHUNK-bit slice subtractor: {bout, d} = a - b - bin.
// The top-level unit reuses this one slice for every chunk of the operands.
module sub_slice #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  assign {bout, d} = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};

endmodule

// File: rtl/serial_subtractor_64bits.sv
// Multi-cycle subtract-with-borrow: diff = a - b - b_in, one CHUNK-bit slice per clock,
// with valid/ready handshakes on both the operand and result sides.
//
//   state | meaning
//   IDLE  | in_ready high; waiting for operands
//   CALC  | one slice per cycle, borrow rippling from low to high chunk
//   DONE  | out_valid high; result held until out_ready
module serial_subtractor_64bits
  import serial_subtractor_64bits_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int N_CHUNKS = n_chunks(WIDTH, CHUNK);
  localparam int IDX_W    = idx_width(N_CHUNKS);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [IDX_W-1:0] idx;
  logic             borrow, b_out_q, ovf_q;
  logic [CHUNK-1:0] a_slice, b_slice, d_slice;
  logic             bw;
  logic             last;

  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < N_CHUNKS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_slice = a_q[i*CHUNK +: CHUNK];
        b_slice = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  sub_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (a_slice),
    .b    (b_slice),
    .bin  (borrow),
    .d    (d_slice),
    .bout (bw)
  );

  assign last = (idx == IDX_W'(N_CHUNKS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      idx     <= '0;
      borrow  <= 1'b0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= b_in;
            idx    <= '0;
          end
        end
        CALC: begin
          for (int i = 0; i < N_CHUNKS; i++) begin
            if (idx == IDX_W'(i)) diff_q[i*CHUNK +: CHUNK] <= d_slice;
          end
          borrow <= bw;
          idx    <= idx + 1'b1;
          // Top slice: sign bit of the result is the MSB of this slice's difference.
          if (last) begin
            b_out_q <= bw;
            ovf_q   <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ d_slice[CHUNK-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff  = diff_q;
  assign b_out = b_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_64bits.sv
// Self-checking bench: directed vector table, handshake/reset sequences and a random
// regression on CHUNK = 16, 8 and 64 against an arithmetic reference model.
module tb_serial_subtractor_64bits;

  logic clk;
  logic rst;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [63:0] a_s       [3];
  logic [63:0] b_s       [3];
  logic        b_in_s    [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [63:0] diff_s    [3];
  logic        b_out_s   [3];
  logic        ovf_s     [3];

  int checks = 0;
  int errors = 0;

  localparam int LAT [3] = '{4, 8, 1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_64bits #(.WIDTH(64), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_s[0]), .b(b_s[0]), .b_in(b_in_s[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .diff(diff_s[0]), .b_out(b_out_s[0]), .ovf(ovf_s[0]));

  serial_subtractor_64bits #(.WIDTH(64), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_s[1]), .b(b_s[1]), .b_in(b_in_s[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .diff(diff_s[1]), .b_out(b_out_s[1]), .ovf(ovf_s[1]));

  serial_subtractor_64bits #(.WIDTH(64), .CHUNK(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_s[2]), .b(b_s[2]), .b_in(b_in_s[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .diff(diff_s[2]), .b_out(b_out_s[2]), .ovf(ovf_s[2]));

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] diff;
    logic        bout;
    logic        ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: unsigned 65-bit difference for borrow, sign-extended 65-bit for overflow.
  function automatic logic [65:0] model(input logic [63:0] av, input logic [63:0] bv, input logic bi);
    logic [64:0] u;
    logic signed [64:0] s;
    u = {1'b0, av} - {1'b0, bv} - 65'(bi);
    s = $signed({av[63], av}) - $signed({bv[63], bv}) - $signed({64'd0, bi});
    return {s[64] ^ s[63], u[64], u[63:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int k, input logic [63:0] av, input logic [63:0] bv, input logic bi,
                        output logic [63:0] dv, output logic bo, output logic ov, output int lat);
    int w;
    w = 0;
    while (!in_ready[k] && w < 50) begin
      tick();
      w++;
    end
    in_valid[k] = 1'b1;
    a_s[k]      = av;
    b_s[k]      = bv;
    b_in_s[k]   = bi;
    tick();
    in_valid[k] = 1'b0;
    a_s[k]      = ~av;
    b_s[k]      = ~bv;
    lat = 0;
    while (!out_valid[k] && lat < 30) begin
      tick();
      lat++;
    end
    if (!out_valid[k]) lat = -1;
    dv = diff_s[k];
    bo = b_out_s[k];
    ov = ovf_s[k];
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] dv, ea, eb;
    logic        bo, ov, eb_in;
    logic [65:0] m;
    int          lat, w;

    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      a_s[k] = '0; b_s[k] = '0; b_in_s[k] = 1'b0;
    end

    vecs[0] = '{64'd100, 64'd58, 1'b0, 64'd42, 1'b0, 1'b0};
    vecs[1] = '{64'h0000_0000_0001_0000, 64'd1, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0};
    vecs[2] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    vecs[4] = '{64'd5, 64'd5, 1'b0, 64'd0, 1'b0, 1'b0};
    vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};

    do_reset();
    check("reset_out_valid", 64'(out_valid[0]), 64'd0);
    check("reset_in_ready",  64'(in_ready[0]),  64'd1);
    check("reset_diff",      diff_s[0],         64'd0);
    check("reset_b_out",     64'(b_out_s[0]),   64'd0);
    check("reset_ovf",       64'(ovf_s[0]),     64'd0);

    // Directed vectors on the default CHUNK=16 instance.
    for (int i = 0; i < 7; i++) begin
      run_op(0, vecs[i].a, vecs[i].b, vecs[i].bin, dv, bo, ov, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      check($sformatf("vec%0d_diff", i), dv, vecs[i].diff);
      check($sformatf("vec%0d_b_out", i), 64'(bo), 64'(vecs[i].bout));
      check($sformatf("vec%0d_ovf", i), 64'(ov), 64'(vecs[i].ovf));
      check($sformatf("vec%0d_release", i), 64'(out_valid[0]), 64'd0);
    end

    // Stall in DONE, with a stray in_valid pulse during CALC.
    m = model(64'd1000, 64'd1, 1'b0);
    w = 0;
    while (!in_ready[0] && w < 50) begin tick(); w++; end
    in_valid[0] = 1'b1; a_s[0] = 64'd1000; b_s[0] = 64'd1; b_in_s[0] = 1'b0;
    tick();
    a_s[0] = 64'd7; b_s[0] = 64'd9; b_in_s[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    w = 0;
    while (!out_valid[0] && w < 30) begin tick(); w++; end
    check("stall_reached_done", 64'(out_valid[0]), 64'd1);
    for (int c = 0; c < 10; c++) begin
      check("stall_out_valid", 64'(out_valid[0]), 64'd1);
      check("stall_diff", diff_s[0], m[63:0]);
      check("stall_in_ready", 64'(in_ready[0]), 64'd0);
      tick();
    end
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    check("stall_drop_valid", 64'(out_valid[0]), 64'd0);
    check("stall_in_ready_back", 64'(in_ready[0]), 64'd1);

    // Reset during the second CALC cycle.
    in_valid[0] = 1'b1; a_s[0] = 64'd12345; b_s[0] = 64'd345; b_in_s[0] = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    check("midrst_diff", diff_s[0], 64'd0);
    check("midrst_in_ready", 64'(in_ready[0]), 64'd1);
    run_op(0, 64'd2000, 64'd5, 1'b0, dv, bo, ov, lat);
    check("post_rst_diff", dv, 64'd1995);
    check("post_rst_latency", 64'(lat), 64'd4);

    // Random regression across all three chunk sizes.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        ea    = {$urandom, $urandom};
        eb    = {$urandom, $urandom};
        eb_in = 1'($urandom_range(0, 1));
        if (n % 8 == 1) eb = ea;
        if (n % 8 == 3) ea = {ea[63], 63'd0};
        m = model(ea, eb, eb_in);
        run_op(k, ea, eb, eb_in, dv, bo, ov, lat);
        check($sformatf("rnd_k%0d_latency", k), 64'(lat), 64'(LAT[k]));
        check($sformatf("rnd_k%0d_diff", k), dv, m[63:0]);
        check($sformatf("rnd_k%0d_b_out", k), 64'(bo), 64'(m[64]));
        check($sformatf("rnd_k%0d_ovf", k), 64'(ov), 64'(m[65]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
